// File: rtl/lc3b_pkg.sv
// Shared LC-3b memory-path definitions.
// Holds the access-size encoding (also used by MDR_STORE), the memory access
// sequencer state encoding and the byte write-enable encodings.
package lc3b_pkg;

  // Access size as driven by the control store DATA.SIZE field.
  localparam logic DATA_BYTE = 1'b0;
  localparam logic DATA_WORD = 1'b1;

  // Memory access sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    LATCH  = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } mac_state_e;

  // Byte write enables: bit0 = low byte, bit1 = high byte.
  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_BOTH = 2'b11;

  // Write-enable pattern for a write of the given size at the given MAR[0].
  function automatic logic [1:0] write_enables(input logic data_size, input logic mar0);
    if (data_size == DATA_WORD) begin
      return WE_BOTH;
    end
    return mar0 ? WE_HI : WE_LO;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for the memory ready handshake.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clr_i        synchronous clear to 0 (has priority over en_i)
//   en_i         increment by one
//   expired_o    high while the count equals MAX_WAIT-1
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3b memory access sequencer.
// Accepts one access request from the microsequencer, drives memory enable,
// byte write enables, the MDR input select and the MDR load strobe, waits for
// mem_ready with a bounded timeout and rejects unaligned word accesses.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   req, rw, data_size, mar0   request and its captured attributes (IDLE only)
//   mem_ready           memory R handshake (sampled in ACCESS only)
//   mem_en, mem_we      memory enable and byte write enables
//   mio_en, ld_mdr      MDR input select (1 = memory) and load strobe
//   busy, done, err     status: not idle, completion pulse, error qualifier
module mem_access_ctrl
  import lc3b_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rw,
  input  logic       data_size,
  input  logic       mar0,
  input  logic       mem_ready,
  output logic       mem_en,
  output logic [1:0] mem_we,
  output logic       mio_en,
  output logic       ld_mdr,
  output logic       busy,
  output logic       done,
  output logic       err
);

  mac_state_e state_d, state_q;
  logic       rw_d, rw_q;
  logic       size_d, size_q;
  logic       mar0_d, mar0_q;
  logic       timer_clr, timer_en, timer_expired;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  // Counter is held at zero outside ACCESS so every access starts fresh.
  assign timer_clr = (state_q != ACCESS);
  assign timer_en  = (state_q == ACCESS) && !mem_ready;

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    size_d  = size_q;
    mar0_d  = mar0_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          rw_d   = rw;
          size_d = data_size;
          mar0_d = mar0;
          state_d = (data_size == DATA_WORD && mar0) ? FAULT : ACCESS;
        end
      end
      ACCESS: begin
        // Ready on the final allowed cycle still completes normally.
        if (mem_ready) begin
          state_d = rw_q ? DONE : LATCH;
        end else if (timer_expired) begin
          state_d = FAULT;
        end
      end
      LATCH:   state_d = DONE;
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      size_q  <= DATA_BYTE;
      mar0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      mar0_q  <= mar0_d;
    end
  end

  // Outputs decode from state and captured request only, so an asynchronous
  // reset forces them all to zero immediately.
  always_comb begin
    mem_en = 1'b0;
    mem_we = WE_NONE;
    mio_en = 1'b0;
    ld_mdr = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    unique case (state_q)
      ACCESS: begin
        mem_en = 1'b1;
        if (rw_q) begin
          mem_we = write_enables(size_q, mar0_q);
        end else begin
          mio_en = 1'b1;
        end
      end
      LATCH: begin
        mio_en = 1'b1;
        ld_mdr = 1'b1;
      end
      DONE: done = 1'b1;
      FAULT: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: two instances (MAX_WAIT 15 and 3)
// share stimulus; a vector table drives one access each and a scoreboard of
// expected per-access results is popped when done is observed.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       rw = 1'b0;
  logic       data_size = 1'b0;
  logic       mar0 = 1'b0;
  logic       mem_ready = 1'b0;

  // {mem_en, mem_we[1:0], mio_en, ld_mdr, busy, done, err}
  logic [7:0] outs [2];

  logic       a_en, a_mio, a_ld, a_busy, a_done, a_err;
  logic [1:0] a_we;
  logic       b_en, b_mio, b_ld, b_busy, b_done, b_err;
  logic [1:0] b_we;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .data_size(data_size), .mar0(mar0),
    .mem_ready(mem_ready), .mem_en(a_en), .mem_we(a_we), .mio_en(a_mio), .ld_mdr(a_ld),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  mem_access_ctrl #(.MAX_WAIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .data_size(data_size), .mar0(mar0),
    .mem_ready(mem_ready), .mem_en(b_en), .mem_we(b_we), .mio_en(b_mio), .ld_mdr(b_ld),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  assign outs[0] = {a_en, a_we, a_mio, a_ld, a_busy, a_done, a_err};
  assign outs[1] = {b_en, b_we, b_mio, b_ld, b_busy, b_done, b_err};

  typedef struct {
    string name;
    int    sel;       // 0 = MAX_WAIT 15 instance, 1 = MAX_WAIT 3 instance
    logic  rw;
    logic  size;
    logic  mar0;
    int    wait_cyc;  // mem_ready low for this many ACCESS-phase cycles; 255 = never
    int    exp_access;
    int    exp_we;    // OR of mem_we over the access
    int    exp_mio;   // mio_en ever high
    int    exp_ld;    // cycles with ld_mdr high
    int    exp_err;
    int    exp_done;  // cycle of done, req sampled in cycle 0
  } vec_t;

  vec_t vecs [10];
  vec_t sb [$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((a_busy || b_busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", int'(a_busy || b_busy), 0);
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    logic [7:0] o;
    int acc = 0, ldc = 0, busyc = 0, we_or = 0, mio_or = 0, got = 0, dcyc = 0, derr = 0;
    wait_idle();
    rw = v.rw; data_size = v.size; mar0 = v.mar0; req = 1'b1; mem_ready = 1'b0;
    sb.push_back(v);
    for (int c = 1; c <= 40 && got == 0; c++) begin
      @(posedge clk); #1;
      req = 1'b0;
      o = outs[v.sel];
      mem_ready = (v.wait_cyc != 255) && (c > v.wait_cyc);
      acc    += int'(o[7]);
      we_or  |= int'(o[6:5]);
      mio_or |= int'(o[4]);
      ldc    += int'(o[3]);
      busyc  += int'(o[2]);
      if (o[1]) begin
        got  = 1;
        dcyc = c;
        derr = int'(o[0]);
      end
    end
    mem_ready = 1'b0;
    check({v.name, "_done_seen"}, got, 1);
    if (got != 0 && sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, "_done_cycle"}, dcyc, e.exp_done);
      check({e.name, "_err"}, derr, e.exp_err);
      check({e.name, "_access_cycles"}, acc, e.exp_access);
      check({e.name, "_mem_we"}, we_or, e.exp_we);
      check({e.name, "_mio_en"}, mio_or, e.exp_mio);
      check({e.name, "_ld_mdr"}, ldc, e.exp_ld);
      check({e.name, "_busy_cycles"}, busyc, e.exp_done);
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    int dn, bc, derr;
    //        name        sel rw  sz   m0   wait acc we mio ld err done
    vecs[0] = '{"rd_word",    0, 0, 1'b1, 0, 0,   1, 0, 1, 1, 0, 3};
    vecs[1] = '{"wr_byte_hi", 0, 1, 1'b0, 1, 4,   5, 2, 0, 0, 0, 6};
    vecs[2] = '{"rd_unalign", 0, 0, 1'b1, 1, 0,   0, 0, 0, 0, 1, 1};
    vecs[3] = '{"wr_byte_lo", 0, 1, 1'b0, 0, 0,   1, 1, 0, 0, 0, 2};
    vecs[4] = '{"wr_word",    0, 1, 1'b1, 0, 2,   3, 3, 0, 0, 0, 4};
    vecs[5] = '{"rd_byte_hi", 0, 0, 1'b0, 1, 1,   2, 0, 1, 1, 0, 4};
    vecs[6] = '{"rd_timeout", 1, 0, 1'b1, 0, 255, 3, 0, 1, 0, 1, 4};
    vecs[7] = '{"rd_last_rdy",1, 0, 1'b1, 0, 2,   3, 0, 1, 1, 0, 5};
    vecs[8] = '{"wr_timeout", 1, 1, 1'b1, 0, 255, 3, 3, 0, 0, 1, 4};
    vecs[9] = '{"wr_unalign", 0, 1, 1'b1, 1, 0,   0, 0, 0, 0, 1, 1};

    // Reset state.
    #3;
    check("reset_outs_a", int'(outs[0]), 0);
    check("reset_outs_b", int'(outs[1]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_outs_a", int'(outs[0]), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // req held during ACCESS is ignored: exactly one done per accepted request.
    wait_idle();
    rw = 1'b1; data_size = 1'b0; mar0 = 1'b0; req = 1'b1; mem_ready = 1'b0;
    dn = 0; derr = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      req = (c < 3);
      mem_ready = (c >= 3) && (c <= 3);
      dn += int'(a_done);
      derr |= int'(a_done & a_err);
    end
    mem_ready = 1'b0;
    check("req_busy_one_done", dn, 1);
    check("req_busy_no_err", derr, 0);

    // Asynchronous reset during ACCESS abandons the access.
    wait_idle();
    rw = 1'b0; data_size = 1'b1; mar0 = 1'b0; req = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    check("pre_reset_mem_en", int'(a_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs_a", int'(outs[0]), 0);
    check("async_reset_outs_b", int'(outs[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0; bc = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      dn += int'(a_done) + int'(b_done);
      bc += int'(a_busy) + int'(b_busy);
    end
    check("after_reset_no_done", dn, 0);
    check("after_reset_not_busy", bc, 0);

    // Normal operation resumes after the abandoned access.
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
